mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Shares one 4-bit 2:1 mux datapath between two requesters, A and B.
- Round-robin arbiter with a per-grant burst limit drives the mux `sel`.
- Exposes a valid/ready beat interface to a single downstream consumer.
- Sits directly in front of the team's 2:1 mux and is the only agent allowed to drive its select.

Parameters:
- DATA_W, 4, width of each requester's data and of out_data.
- MAX_BURST, 4, maximum beats per grant while the other side is waiting; legal range 1..255.
- CNT_W, 16, width of the grant statistics counters; only used with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A has a beat pending; held until beat accepted.
- data_a  input  DATA_W  requester A data; stable while req_a is high.
- req_b  input  1  requester B has a beat pending.
- data_b  input  DATA_W  requester B data.
- gnt_a  output  1  A owns the mux; registered.
- gnt_b  output  1  B owns the mux; registered.
- sel  output  1  mux select; 1 = A, 0 = B; registered, equals gnt_a.
- out_data  output  DATA_W  mux output: data_a when sel=1, else data_b; combinational.
- out_valid  output  1  (gnt_a & req_a) | (gnt_b & req_b); combinational.
- out_ready  input  1  downstream accepts; beat = out_valid & out_ready.
- cnt_a  output  CNT_W  grants issued to A (optional feature only).
- cnt_b  output  CNT_W  grants issued to B (optional feature only).

Behaviour:
- Clock/reset: one clock, `clk`. Reset `reset` is asynchronous and active-high.
- Reset values:
  - state=IDLE, gnt_a=0, gnt_b=0, sel=0.
  - priority pointer=A, burst counter=0, cnt_a=0, cnt_b=0.
  - out_valid is therefore 0.
- States: IDLE, GRANT_A, GRANT_B. Exactly one or zero grants are high at any time.
- IDLE:
  - req_a only -> GRANT_A.
  - req_b only -> GRANT_B.
  - Both -> the side named by the priority pointer.
  - Neither -> stay in IDLE.
  - Grant latency is 1 cycle: a req seen at edge N gives gnt high after edge N.
- GRANT_X, where Y is the other side:
  - Each beat increments the burst counter.
  - If req_x is low at a clock edge, release: go to GRANT_Y if req_y, else IDLE. Counter clears; pointer moves to Y.
  - If a beat occurs with counter == MAX_BURST-1 and req_y is high: go to GRANT_Y, counter clears, pointer moves to Y.
  - If a beat occurs with counter == MAX_BURST-1 and req_y is low: stay in GRANT_X, counter clears; the burst limit only applies under contention.
  - Otherwise: stay in GRANT_X.
- Handover: GRANT_A to GRANT_B is direct, with no IDLE bubble. The new owner may beat in its first granted cycle.
- out_ready low: the counter holds and the grant holds; there is no timeout.
- Requester contract: a requester must not drop req while gnt & out_ready & its req are all high before the edge. A drop is treated as release; the data is not lost, because no beat occurred.
- Reset mid-burst: asynchronous return to the reset values. Any partially counted burst is discarded.
- Starvation bound: with both sides requesting and out_ready=1, each side waits at most MAX_BURST+1 cycles.

Optional Feature:
- Macro: MUX_RR_ARBITER_STATS_EN.
- Defined:
  - cnt_a/cnt_b increment on each transition into GRANT_A/GRANT_B respectively.
  - Counters wrap modulo 2^CNT_W.
  - Counters are cleared by reset.
- Undefined:
  - cnt_a/cnt_b are tied to 0.
  - No counter flops are present.
  - Port list is unchanged.

Decomposition:
- Package mux_arb_pkg contains:
  - state encoding constants ARB_IDLE=2'd0, ARB_GNT_A=2'd1, ARB_GNT_B=2'd2.
  - constant SEL_A=1'b1.
- One sub-module, the team's existing 4-bit 2:1 mux, instantiated for out_data with sel as its select.
- Burst counter and FSM stay in the top module.

Test Plan:
- Reset, then req_a=1 only, data_a=4'hA, out_ready=1 -> gnt_a=1 and sel=1 on the next cycle; out_data=4'hA, out_valid=1; gnt_b stays 0.
- req_a=req_b=1 raised together from IDLE after reset -> A granted first (pointer=A); with MAX_BURST=4 and out_ready=1: exactly 4 beats of A, then gnt_b=1 the very next cycle with no IDLE gap; B gets 4 beats, then A again.
- GRANT_A with req_b=0 and req_a held for 10 beats -> gnt_a stays 1 for all 10 beats; the counter wraps every 4 beats without a grant change.
- GRANT_A, out_ready=0 for 6 cycles while req_b=1 -> grant held, no beats counted; after out_ready=1, 4 beats of A, then B.
- GRANT_B mid-burst (2 beats done), assert reset for 1 cycle -> gnt_b=0 and sel=0 immediately (asynchronous); after release with both requests high, A granted first.
- With MUX_RR_ARBITER_STATS_EN, CNT_W=4, alternate grants 17 times to A -> cnt_a=4'h1 (wrapped); without the macro, cnt_a=cnt_b=0 throughout.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared encodings for the round-robin arbiter in front of the 2:1 data mux.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_A = 2'd1,
        ARB_GNT_B = 2'd2
    } arb_state_e;

    localparam logic SEL_A = 1'b1;

    // Burst counter is sized for the largest legal MAX_BURST (255).
    localparam int BURST_W = 8;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// 2:1 data mux; select high routes requester A to the output.
module mux_rr_arbiter_mux
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out
);

    assign out = (sel == SEL_A) ? in_a : in_b;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with per-grant burst limit driving a shared 2:1 mux.
// Grant statistics counters exist only when MUX_RR_ARBITER_STATS_EN is defined.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic               ptr_a_q, ptr_a_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               beat;

    assign gnt_a     = (state_q == ARB_GNT_A);
    assign gnt_b     = (state_q == ARB_GNT_B);
    assign sel       = gnt_a;
    assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
    assign beat      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        ptr_a_d = ptr_a_q;
        burst_d = burst_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_a && (!req_b || ptr_a_q)) begin
                    state_d = ARB_GNT_A;
                end else if (req_b) begin
                    state_d = ARB_GNT_B;
                end
            end
            ARB_GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? ARB_GNT_B : ARB_IDLE;
                    burst_d = '0;
                    ptr_a_d = 1'b0;
                end else if (beat) begin
                    // Burst limit only forces a handover when B is waiting.
                    if (burst_q == BURST_LAST) begin
                        burst_d = '0;
                        if (req_b) begin
                            state_d = ARB_GNT_B;
                            ptr_a_d = 1'b0;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            ARB_GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? ARB_GNT_A : ARB_IDLE;
                    burst_d = '0;
                    ptr_a_d = 1'b1;
                end else if (beat) begin
                    if (burst_q == BURST_LAST) begin
                        burst_d = '0;
                        if (req_a) begin
                            state_d = ARB_GNT_A;
                            ptr_a_d = 1'b1;
                        end
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            ptr_a_q <= 1'b1;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_a_q <= ptr_a_d;
            burst_q <= burst_d;
        end
    end

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Count entries into a grant state, not cycles spent in it.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (state_d == ARB_GNT_A && state_q != ARB_GNT_A) begin
            cnt_a_d = cnt_a_q + CNT_W'(1);
        end
        if (state_d == ARB_GNT_B && state_q != ARB_GNT_B) begin
            cnt_b_d = cnt_b_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
`else
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

    mux_rr_arbiter_mux #(
        .WIDTH (DATA_W)
    ) u_mux (
        .sel  (sel),
        .in_a (data_a),
        .in_b (data_b),
        .out  (out_data)
    );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected beats {owner,data} are queued as
// stimulus is driven and popped as the DUT hands out each accepted beat.
module tb_mux_rr_arbiter;

    localparam int DW = 4;
    localparam int MB = 4;
    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          req_a, req_b, out_ready;
    logic [DW-1:0] data_a, data_b, out_data;
    logic          gnt_a, gnt_b, sel, out_valid;
    logic [CW-1:0] cnt_a, cnt_b;

    int            n_assert;
    int            n_fail;
    logic [4:0]    exp_q[$];
    logic [3:0]    da, db;   // data currently presented by each requester
    logic [3:0]    pa, pb;   // next data value to be queued as expected

    mux_rr_arbiter #(
        .DATA_W    (DW),
        .MAX_BURST (MB),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b1, pa});
            pa = pa + 4'd1;
        end
    endtask

    task automatic push_b(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, pb});
            pb = pb + 4'd1;
        end
    endtask

    // One clock: score any beat at the negedge, then advance the requester
    // whose beat was accepted to its next data word just after the posedge.
    task automatic cyc(input string tag);
        logic       hit;
        logic       was_a;
        logic [4:0] e;
        hit   = 1'b0;
        was_a = 1'b0;
        @(negedge clk);
`ifndef MUX_RR_ARBITER_STATS_EN
        chk({tag, "_cnt_a_zero"}, 32'(cnt_a), 32'd0);
        chk({tag, "_cnt_b_zero"}, 32'(cnt_b), 32'd0);
`endif
        if (out_valid && out_ready) begin
            hit   = 1'b1;
            was_a = sel;
            chk({tag, "_beat_expected"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({tag, "_beat"}, 32'({sel, out_data}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
        if (hit) begin
            if (was_a) begin
                da     = da + 4'd1;
                data_a = da;
            end else begin
                db     = db + 4'd1;
                data_b = db;
            end
        end
    endtask

    // mode 0: no per-cycle check, 1: some grant held, 2: gnt_a held
    task automatic run(input string tag, input int budget, input int mode);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            cyc(tag);
            n++;
            if (exp_q.size() > 0) begin
                if (mode == 1) chk({tag, "_no_gap"}, 32'(gnt_a | gnt_b), 32'd1);
                if (mode == 2) chk({tag, "_gnt_a_held"}, 32'(gnt_a), 32'd1);
            end
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        da        = 4'hA;
        pa        = 4'hA;
        db        = 4'h5;
        pb        = 4'h5;
        reset     = 1'b1;
        req_a     = 1'b0;
        req_b     = 1'b0;
        data_a    = da;
        data_b    = db;
        out_ready = 1'b0;

        // reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_gnt_a", 32'(gnt_a), 32'd0);
        chk("rst_gnt_b", 32'(gnt_b), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_cnt_b", 32'(cnt_b), 32'd0);
        reset = 1'b0;

        // single requester A: one cycle of grant latency, then one beat
        out_ready = 1'b1;
        push_a(1);
        req_a = 1'b1;
        cyc("t1_idle");
        chk("t1_gnt_a", 32'(gnt_a), 32'd1);
        chk("t1_sel", 32'(sel), 32'd1);
        chk("t1_gnt_b", 32'(gnt_b), 32'd0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA);
        cyc("t1_beat");
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        req_a = 1'b0;
        cyc("t1_release");
        chk("t1_idle_after", 32'(gnt_a | gnt_b), 32'd0);

        // contention from reset: A first, 4/4/4 with direct handovers
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        push_a(MB);
        push_b(MB);
        push_a(MB);
        run("t2", 40, 1);
        chk("t2_handover_to_b", 32'(gnt_b), 32'd1);
        req_a = 1'b0;
        req_b = 1'b0;
        cyc("t2_release");

        // A alone for 10 beats: burst counter wraps with no grant change
        do_reset();
        req_a = 1'b1;
        push_a(10);
        run("t3", 30, 2);
        chk("t3_gnt_a_after", 32'(gnt_a), 32'd1);
        req_a = 1'b0;
        cyc("t3_release");

        // backpressure holds grant and counter, then 4 A beats and B
        do_reset();
        out_ready = 1'b0;
        req_a     = 1'b1;
        req_b     = 1'b1;
        cyc("t4_grant");
        for (int i = 0; i < 6; i++) begin
            cyc("t4_stall");
            chk("t4_stall_gnt_a", 32'(gnt_a), 32'd1);
        end
        out_ready = 1'b1;
        push_a(MB);
        push_b(MB);
        run("t4", 40, 1);
        req_a = 1'b0;
        req_b = 1'b0;
        cyc("t4_release");

        // asynchronous reset in the middle of a B burst
        do_reset();
        req_b = 1'b1;
        push_b(2);
        run("t5_pre", 20, 0);
        chk("t5_gnt_b_mid", 32'(gnt_b), 32'd1);
        req_a = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_gnt_b", 32'(gnt_b), 32'd0);
        chk("t5_async_sel", 32'(sel), 32'd0);
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_a(MB);
        push_b(1);
        run("t5_post", 30, 1);
        req_a = 1'b0;
        req_b = 1'b0;
        cyc("t5_release");

        // 17 alternating single-beat grants to each side
        do_reset();
        for (int k = 0; k < 17; k++) begin
            push_a(1);
            req_a = 1'b1;
            run("t6_a", 10, 0);
            req_a = 1'b0;
            cyc("t6_a_rel");
            push_b(1);
            req_b = 1'b1;
            run("t6_b", 10, 0);
            req_b = 1'b0;
            cyc("t6_b_rel");
        end
`ifdef MUX_RR_ARBITER_STATS_EN
        chk("t6_cnt_a_wrap", 32'(cnt_a), 32'd1);
        chk("t6_cnt_b_wrap", 32'(cnt_b), 32'd1);
`else
        chk("t6_cnt_a_off", 32'(cnt_a), 32'd0);
        chk("t6_cnt_b_off", 32'(cnt_b), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
